// File: rtl/timer_irq_pkg.sv
// rtl/timer_irq_pkg.sv - register map, bit positions, reset values and byte merge helper for timer_irq
package timer_irq_pkg;

    localparam logic [1:0] REG_CMP    = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_IRQ_EN      = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int STATUS_PENDING   = 0;
    localparam int STATUS_IRQ       = 1;

    localparam logic [31:0] CMP_RESET_DEFAULT = 32'hFFFF_FFFF;
    localparam logic [31:0] PERIOD_RESET      = 32'h0000_0000;
    localparam logic [1:0]  CTRL_RESET        = 2'b00;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] result;
        result = old;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                result[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_irq_if.sv
// rtl/timer_irq_if.sv - picorv32 native bus slice seen by the timer_irq peripheral
interface timer_irq_if;
    logic        enable;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_instr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;

    modport master (
        output enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  enable, mem_valid, mem_instr, mem_wstrb, mem_wdata, mem_addr,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/timer_irq_cmp.sv
// rtl/timer_irq_cmp.sv - compare/period registers, match detection and periodic reload
module timer_irq_cmp
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] CMP_RESET = CMP_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] count,
    input  logic        auto_reload,
    input  logic        wr_cmp,
    input  logic        wr_period,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] cmp,
    output logic [31:0] period,
    output logic        match
);

    assign match = (count == cmp);

    // A software write to CMP overrides the reload; the reload always
    // uses the PERIOD value held before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp    <= CMP_RESET;
            period <= PERIOD_RESET;
        end else begin
            if (wr_cmp) begin
                cmp <= merge_bytes(cmp, wdata, wstrb);
            end else if (match && auto_reload) begin
                cmp <= cmp + period;
            end
            if (wr_period) begin
                period <= merge_bytes(period, wdata, wstrb);
            end
        end
    end

endmodule

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - timer compare interrupt peripheral on the picorv32 native bus
module timer_irq
    import timer_irq_pkg::*;
#(
    parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    timer_irq_if.slave  bus,
    input  logic [31:0] count,
    output logic        irq
);

    logic        rdy;
    logic        commit;
    logic        wr;
    logic [1:0]  sel;
    logic [1:0]  ctrl;
    logic        pending;
    logic        match;
    logic        w1c;
    logic [31:0] cmp;
    logic [31:0] period;
    logic [31:0] rdata_mux;
    logic        unused_bus;

    assign unused_bus = &{1'b0, bus.mem_instr, bus.mem_addr[31:4], bus.mem_addr[1:0]};

    // Writes commit on the edge that raises rdy, so each access commits once.
    assign commit = bus.mem_valid & bus.enable & ~rdy;
    assign wr     = commit & (bus.mem_wstrb != 4'b0000);
    assign sel    = bus.mem_addr[3:2];
    assign w1c    = wr && (sel == REG_STATUS) && bus.mem_wstrb[0]
                    && bus.mem_wdata[STATUS_PENDING];

    timer_irq_cmp #(.CMP_RESET(CMP_RESET)) u_cmp (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .auto_reload (ctrl[CTRL_AUTO_RELOAD]),
        .wr_cmp      (wr && (sel == REG_CMP)),
        .wr_period   (wr && (sel == REG_PERIOD)),
        .wdata       (bus.mem_wdata),
        .wstrb       (bus.mem_wstrb),
        .cmp         (cmp),
        .period      (period),
        .match       (match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            rdy     <= 1'b0;
            ctrl    <= CTRL_RESET;
            pending <= 1'b0;
            irq     <= 1'b0;
        end else begin
            rdy <= commit;
            if (wr && (sel == REG_CTRL) && bus.mem_wstrb[0]) begin
                ctrl <= bus.mem_wdata[1:0];
            end
            if (match) begin
                pending <= 1'b1;
            end else if (w1c) begin
                pending <= 1'b0;
            end
            irq <= pending & ctrl[CTRL_IRQ_EN];
        end
    end

    always_comb begin
        rdata_mux = 32'h0000_0000;
        case (sel)
            REG_CMP:    rdata_mux = cmp;
            REG_PERIOD: rdata_mux = period;
            REG_CTRL:   rdata_mux = {30'b0, ctrl};
            REG_STATUS: begin
                rdata_mux[STATUS_PENDING] = pending;
                rdata_mux[STATUS_IRQ]     = irq;
            end
            default:    rdata_mux = 32'h0000_0000;
        endcase
    end

    assign bus.mem_ready = bus.enable ? rdy : 1'bz;
    assign bus.mem_rdata = bus.enable ? rdata_mux : 32'bz;

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - directed bench for timer_irq
module tb_timer_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] count;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    timer_irq_if bus ();

    timer_irq #(.CMP_RESET(32'hFFFF_FFFF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  idx;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_addr(input logic [1:0] idx);
        return {28'h1000_000, idx, 2'b00};
    endfunction

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(idx);
        bus.mem_wdata = d;
        bus.mem_wstrb = s;
        @(posedge clk);
        #1 check("wr_ready_pulse", {31'b0, bus.mem_ready}, 32'd1);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk);
        #1 check("wr_ready_drop", {31'b0, bus.mem_ready}, 32'd0);
    endtask

    task automatic bus_read(input logic [1:0] idx, output logic [31:0] d);
        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(idx);
        bus.mem_wstrb = 4'b0000;
        @(posedge clk);
        #1 check("rd_ready_pulse", {31'b0, bus.mem_ready}, 32'd1);
        d = bus.mem_rdata;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        @(posedge clk);
        #1 check("rd_ready_drop", {31'b0, bus.mem_ready}, 32'd0);
    endtask

    // Advance the timer at negedge, then sample just after the next posedge.
    task automatic step(input logic [31:0] c, input logic [1:0] idx);
        @(negedge clk);
        count         = c;
        bus.mem_addr  = reg_addr(idx);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] rst_exp [4];

        vecs[0] = '{2'd0, 32'h0000_0000, 4'b1111, 32'h0000_0000};
        vecs[1] = '{2'd0, 32'hAABB_CCDD, 4'b0101, 32'h00BB_00DD};
        vecs[2] = '{2'd0, 32'h1122_3344, 4'b1010, 32'h11BB_33DD};
        vecs[3] = '{2'd1, 32'h0000_0020, 4'b1111, 32'h0000_0020};
        vecs[4] = '{2'd1, 32'hFFFF_FFFF, 4'b0010, 32'h0000_FF20};
        vecs[5] = '{2'd2, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0003};
        vecs[6] = '{2'd2, 32'h0000_0000, 4'b1111, 32'h0000_0000};
        vecs[7] = '{2'd3, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000};
        vecs[8] = '{2'd1, 32'h0000_0000, 4'b1111, 32'h0000_0000};
        rst_exp = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0};

        reset         = 1'b1;
        count         = 32'h5555_0000;
        bus.enable    = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus.mem_wdata = 32'h0;
        bus.mem_addr  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset_irq", {31'b0, irq}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), rd);
            check($sformatf("reset_reg%0d", i), rd, rst_exp[i]);
        end

        for (int i = 0; i < 9; i++) begin
            bus_write(vecs[i].idx, vecs[i].wdata, vecs[i].wstrb);
            bus_read(vecs[i].idx, rd);
            check($sformatf("vec%0d", i), rd, vecs[i].exp);
        end

        @(negedge clk);
        reset         = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(2'd0);
        bus.mem_wdata = 32'h0000_2222;
        bus.mem_wstrb = 4'b1111;
        @(posedge clk);
        #1 check("midreset_ready", {31'b0, bus.mem_ready}, 32'd0);
        @(negedge clk);
        reset         = 1'b0;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus_read(2'd0, rd);
        check("midreset_cmp", rd, 32'hFFFF_FFFF);

        // One-shot interrupt
        @(negedge clk);
        count = 32'd90;
        bus_write(2'd0, 32'd100, 4'b1111);
        bus_write(2'd2, 32'd1, 4'b1111);
        step(32'd99, 2'd3);
        check("oneshot_before", bus.mem_rdata, 32'd0);
        step(32'd100, 2'd3);
        check("oneshot_pending", bus.mem_rdata, 32'd1);
        check("oneshot_irq_p1", {31'b0, irq}, 32'd0);
        step(32'd101, 2'd3);
        check("oneshot_status_p2", bus.mem_rdata, 32'd3);
        check("oneshot_irq_p2", {31'b0, irq}, 32'd1);

        @(negedge clk);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(2'd3);
        bus.mem_wdata = 32'd1;
        bus.mem_wstrb = 4'b0001;
        @(posedge clk);
        #1 check("w1c_irq_p1", {31'b0, irq}, 32'd1);
        check("w1c_status_p1", bus.mem_rdata, 32'd2);
        @(negedge clk);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        @(posedge clk);
        #1 check("w1c_irq_p2", {31'b0, irq}, 32'd0);
        bus_read(2'd0, rd);
        check("oneshot_cmp_kept", rd, 32'd100);

        // Auto-reload with wrap
        bus_write(2'd1, 32'h0000_0020, 4'b1111);
        bus_write(2'd0, 32'hFFFF_FFF0, 4'b1111);
        bus_write(2'd2, 32'd3, 4'b1111);
        step(32'hFFFF_FFEF, 2'd0);
        check("reload_before", bus.mem_rdata, 32'hFFFF_FFF0);
        step(32'hFFFF_FFF0, 2'd0);
        check("reload_wrap_cmp", bus.mem_rdata, 32'h0000_0010);
        step(32'h0000_0005, 2'd3);
        check("reload_status", bus.mem_rdata, 32'd3);
        bus_write(2'd3, 32'd1, 4'b0001);
        step(32'h0000_000F, 2'd3);
        check("reload2_before", bus.mem_rdata, 32'd0);
        step(32'h0000_0010, 2'd3);
        check("reload2_pending", bus.mem_rdata, 32'd1);
        step(32'h0000_0011, 2'd0);
        check("reload2_cmp", bus.mem_rdata, 32'h0000_0030);
        bus_write(2'd3, 32'd1, 4'b0001);

        // CMP write in match cycle
        @(negedge clk);
        count         = 32'h0000_0030;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(2'd0);
        bus.mem_wdata = 32'h0000_1234;
        bus.mem_wstrb = 4'b1111;
        @(posedge clk);
        #1 check("conflict_cmp_write", bus.mem_rdata, 32'h0000_1234);
        @(negedge clk);
        count         = 32'h0000_0031;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus.mem_addr  = reg_addr(2'd3);
        @(posedge clk);
        #1 check("conflict_cmp_pending", {31'b0, bus.mem_rdata[0]}, 32'd1);
        bus_write(2'd3, 32'd1, 4'b0001);

        // W1C in match cycle
        @(negedge clk);
        count         = 32'h0000_1234;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(2'd3);
        bus.mem_wdata = 32'd1;
        bus.mem_wstrb = 4'b0001;
        @(posedge clk);
        #1 check("conflict_w1c_pending", {31'b0, bus.mem_rdata[0]}, 32'd1);
        @(negedge clk);
        count         = 32'h0000_1235;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus.mem_addr  = reg_addr(2'd0);
        @(posedge clk);
        #1 check("conflict_w1c_reload", bus.mem_rdata, 32'h0000_1254);

        // PERIOD write during a reload
        @(negedge clk);
        count         = 32'h0000_1254;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(2'd1);
        bus.mem_wdata = 32'h0000_0100;
        bus.mem_wstrb = 4'b1111;
        @(posedge clk);
        #1 check("conflict_period_new", bus.mem_rdata, 32'h0000_0100);
        @(negedge clk);
        count         = 32'h0000_1255;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus.mem_addr  = reg_addr(2'd0);
        @(posedge clk);
        #1 check("conflict_period_old", bus.mem_rdata, 32'h0000_1274);

        // Deselected access must not drive the bus or change state
        @(negedge clk);
        bus.enable    = 1'b0;
        bus.mem_valid = 1'b1;
        bus.mem_addr  = reg_addr(2'd0);
        bus.mem_wdata = 32'h0000_DEAD;
        bus.mem_wstrb = 4'b1111;
        repeat (2) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.mem_ready === 1'b1) begin
                errors++;
                $display("FAIL deselect_ready actual=%b expected=released", bus.mem_ready);
            end
            checks++;
            if (bus.mem_rdata === 32'h0000_1274) begin
                errors++;
                $display("FAIL deselect_rdata actual=%h expected=released", bus.mem_rdata);
            end
        end
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'b0000;
        bus_read(2'd0, rd);
        check("deselect_cmp_kept", rd, 32'h0000_1274);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
# timer_irq

Compare/interrupt unit that sits directly downstream of the free-running 32-bit system timer. It consumes the timer's `count` value and raises `irq` to the picorv32 when `count` reaches a programmed compare value, with optional periodic auto-reload. It is a memory-mapped peripheral on the shared picorv32 native bus, with tri-stated read data and ready outputs.

## Interface
Parameters:
- `CMP_RESET`, 32'hFFFF_FFFF: reset value of the CMP register.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: chip select from the address decoder.
- `mem_valid` in 1: bus request.
- `mem_ready` out 1: bus acknowledge; `1'bz` when `enable`=0.
- `mem_instr` in 1: ignored.
- `mem_wstrb` in 4: byte write strobes; 0 means read.
- `mem_wdata` in 32: write data.
- `mem_addr` in 32: only `[3:2]` is decoded.
- `mem_rdata` out 32: read data; `32'bz` when `enable`=0.
- `count` in 32: timer value. It changes on the timer's negedge, so it is stable at posedge.
- `irq` out 1: registered interrupt request to the CPU.

## Operation
Register map, selected by `mem_addr[3:2]`:
- 0 **CMP**: compare value, R/W, byte-strobed.
- 1 **PERIOD**: reload increment, R/W, byte-strobed.
- 2 **CTRL**: bit0 `irq_en`, bit1 `auto_reload`, R/W. Bits 31:2 read as 0.
- 3 **STATUS**: bit0 `pending`, bit1 `irq`. Read-only except for write-1-to-clear on bit0 (requires `mem_wstrb[0]`).

Match:
- `match` = (`count` == CMP), evaluated every cycle.
- On `match`, `pending` is set.
- On `match` with `auto_reload`=1, CMP <= CMP + PERIOD, modulo 2^32 (the wrap is silently discarded).
- `pending` is set regardless of `irq_en`.

Interrupt:
- `irq` <= `pending` & `irq_en`, registered one cycle.

Conflicting events in one cycle:
- A bus write to CMP and `match` in the same cycle: the write wins, no reload occurs, and `pending` is still set.
- A STATUS W1C and `match` in the same cycle: set wins, so `pending` stays 1.
- A write to PERIOD during a reload cycle: the reload uses the old PERIOD.

Miss behaviour:
- If CMP is written to a value `count` has already passed, the match occurs only after `count` wraps (2^32 cycles). Software is responsible for avoiding this.

## Timing
Reset values:
- CMP = `CMP_RESET`.
- PERIOD = 0.
- CTRL = 0.
- `pending` = 0.
- `irq` = 0.
- internal `rdy` = 0.

Bus handshake:
- `rdy` <= `mem_valid` & `enable` & !`rdy`.
- `mem_ready` is therefore a one-cycle pulse, the cycle after `valid` is sampled, and each access completes in 2 cycles.
- `rdy` is held low for one cycle between back-to-back accesses.
- Writes commit on the same posedge that sets `rdy`; there is exactly one commit per transaction.
- `mem_rdata` is a combinational mux of the current register values, gated by `enable`.

Latencies:
- Match to `pending`: 1 cycle.
- Match to `irq`: 2 cycles.
- STATUS W1C to `irq` low: 2 cycles.

Reset mid-transaction: all state returns to reset values, `rdy` drops, and the in-flight write is discarded.

## Structure
- Package `timer_irq_pkg` holds:
  - register index constants: `REG_CMP`=0, `REG_PERIOD`=1, `REG_CTRL`=2, `REG_STATUS`=3;
  - CTRL/STATUS bit positions;
  - the reset constants.
- A byte-strobe merge function (`old`, `wdata`, `wstrb` to `new`) belongs in the package.
- One sub-module, `timer_irq_cmp`, is natural. It holds CMP, PERIOD, match, reload and write priority. The top level holds the bus decode, handshake, CTRL, STATUS and `irq`.

## Test plan
- **Reset:** assert `reset` for 2 cycles, then read all registers. Expect CMP=FFFF_FFFF, PERIOD=0, CTRL=0, STATUS=0, `irq`=0, and `mem_ready` pulsing exactly 1 cycle per access.
- **One-shot interrupt:** CMP=100, CTRL=1, drive `count` up through 100. Expect `pending` at count 100 +1 cycle and `irq` at +2. Write STATUS=1; expect `irq` low 2 cycles later and CMP still 100.
- **Auto-reload with wrap:** CMP=FFFF_FFF0, PERIOD=0x20, CTRL=3. After the match, expect CMP=0x10. Expect a second match at `count`=0x10 after wrap.
- **Conflicts:** force a CMP write in the match cycle; expect the written value, `pending`=1, no reload. Force a W1C in a match cycle; expect `pending`=1.
- **Byte strobes and tri-state:** write CMP=AABBCCDD with `wstrb`=4'b0101 over 0. Expect 00BB00DD. With `enable`=0 and `mem_valid`=1, expect `mem_rdata`/`mem_ready` high-Z and no register change.
